regfile_port_arbiter: RTL and testbench
=======================================

REGFILE_PORT_ARBITER -- requirements
Module: regfile_port_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register word width.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning register address width (16 registers).
REQ-003 The block SHALL have parameter STARVE_MAX, default 2, meaning the maximum number of consecutive write grants while a read is pending.
REQ-004 Ports SHALL be as follows; one clock; reset is synchronous and active-low:
- clock  in  1  rising-edge clock shared with the register file.
- reset  in  1  synchronous, active-low reset.
- wr0_valid / wr0_ready  in / out  1 / 1  ALU writeback request handshake.
- wr0_addr / wr0_data  in / in  ADDR_W / DATA_W  ALU writeback target and value.
- wr1_valid / wr1_ready  in / out  1 / 1  memory writeback request handshake.
- wr1_addr / wr1_data  in / in  ADDR_W / DATA_W  memory writeback target and value.
- rd_valid / rd_ready  in / out  1 / 1  operand read request handshake.
- rd_addr_a / rd_addr_b  in / in  ADDR_W / ADDR_W  operand addresses.
- rd_resp_valid  out  1  operands valid this cycle.
- rd_data_a / rd_data_b  out / out  DATA_W / DATA_W  operand values.
- rf_enable  out  1  register file write enable.
- rf_in_c  out  ADDR_W  register file write address.
- rf_e  out  DATA_W  register file write data.
- rf_out_a / rf_out_b  out / out  ADDR_W / ADDR_W  register file read addresses.
- rf_a / rf_b  in / in  DATA_W / DATA_W  register file read outputs A and B.

Function
REQ-005 The block SHALL grant at most one of wr0, wr1 or rd per cycle; a transfer occurs when valid and ready are both 1 in the same cycle.
REQ-006 Ready signals SHALL be combinational from the valids and registered state; a requester SHALL hold valid and its payload stable until its transfer completes.
REQ-007 Write grant: rf_enable=1, rf_in_c and rf_e from the granted writer, in the same cycle; the register file commits on that clock edge.
REQ-008 Read grant: rf_enable=0, rf_out_a=rd_addr_a, rf_out_b=rd_addr_b; rd_resp_valid=1 exactly one cycle later.
REQ-009 rd_data_a and rd_data_b SHALL equal rf_a and rf_b while rd_resp_valid=1; their value is don't-care otherwise.
REQ-010 While no read is granted, rf_out_a and rf_out_b SHALL hold the last read-granted addresses (register reset value 0).
REQ-011 Arbitration between writers SHALL be round-robin, using a 1-bit pointer rr.
- Both writers requesting: grant the writer selected by rr, then toggle rr.
- Single writer requesting: grant it and set rr to point at the other writer.
REQ-012 Writes SHALL have priority over reads unless starve_cnt equals STARVE_MAX, in which case the read SHALL be granted.
REQ-013 starve_cnt SHALL increment on each write grant while rd_valid=1, saturating at STARVE_MAX, and SHALL clear on a read grant or when rd_valid=0.
REQ-014 State machine: IDLE (no grant), WRITE (write granted this cycle), READ (read granted this cycle, next cycle drives rd_resp_valid); state is re-decided every cycle per REQ-011 and REQ-012.
REQ-015 There SHALL be no bypass: a read granted in the cycle after a write to the same address returns the new value; a read granted in an earlier cycle returns the old value.
REQ-016 Both writers targeting the same address SHALL be serialized in round-robin order; the last one committed wins.
REQ-017 With no valid request, all ready signals SHALL be 0 and rf_enable=0.

Reset
REQ-018 While reset=0 at a rising edge, the following SHALL clear to 0: rr, starve_cnt, state, rd_resp_valid, and the rf_out_a/rf_out_b registers.
REQ-019 While reset=0, all ready signals and rf_enable SHALL be 0.
REQ-020 A read granted in the cycle before reset asserts SHALL NOT produce rd_resp_valid after reset.
REQ-021 The first grant after reset SHALL use rr=0 (wr0 first).

Structure
REQ-022 DATA_W, ADDR_W and the state encoding SHALL live in the shared package lapido_pkg.
REQ-023 The two-way round-robin writer selection SHALL be a sub-module rr_arbiter2 (req[1:0] -> gnt[1:0], advance input).

Verification
REQ-024 Concurrent writers: wr0 (r3=0x11) and wr1 (r3=0x22) held valid from reset release -> wr0 granted cycle 0, wr1 cycle 1; a following read of r3 returns 0x22.
REQ-025 Read latency: a lone read of a=r5, b=r7 (values 0xA5, 0xB7) -> rd_ready=1 in cycle N, rd_resp_valid=1 in N+1 with data 0xA5/0xB7.
REQ-026 Starvation: both writers continuously valid plus rd_valid -> grant pattern W,W,R repeating; rd_resp_valid follows every R by 1 cycle.
REQ-027 RAW ordering: write r2=0xDEAD in cycle N, read r2 granted in N+1 -> response in N+2 equals 0xDEAD.
REQ-028 Reset mid-operation: reset=0 in the cycle after a read grant -> rd_resp_valid stays 0, all ready signals are 0, and rf_enable=0 while reset=0.
REQ-029 Idle: all valids 0 for 10 cycles -> rf_enable=0, and rf_out_a and rf_out_b are unchanged.

Source files
------------

// File: rtl/lapido_pkg.sv
// Shared widths and arbiter state encoding for the register-file port arbiter.
package lapido_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StRead  = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector; the pointer moves past the granted requester
// only when the caller actually consumes the grant.
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic rr_q, rr_d;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = rr_q ? 2'b10 : 2'b01;
        end
    end

    // After granting wr0 the pointer favours wr1 next, and vice versa.
    always_comb begin
        rr_d = rr_q;
        if (advance && (gnt != 2'b00)) begin
            rr_d = gnt[0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Arbitrates two writeback ports and one operand-read port onto a single-ported
// register file with synchronous reads; reads win after STARVE_MAX write grants.
module regfile_port_arbiter #(
    parameter int unsigned DATA_W     = lapido_pkg::DATA_W,
    parameter int unsigned ADDR_W     = lapido_pkg::ADDR_W,
    parameter int unsigned STARVE_MAX = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr0_valid,
    output logic              wr0_ready,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_valid,
    output logic              wr1_ready,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              rd_resp_valid,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rf_enable,
    output logic [ADDR_W-1:0] rf_in_c,
    output logic [DATA_W-1:0] rf_e,
    output logic [ADDR_W-1:0] rf_out_a,
    output logic [ADDR_W-1:0] rf_out_b,
    input  logic [DATA_W-1:0] rf_a,
    input  logic [DATA_W-1:0] rf_b
);

    import lapido_pkg::*;

    localparam int unsigned SW = $clog2(STARVE_MAX + 2);

    state_e            state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [ADDR_W-1:0] out_a_q, out_a_d;
    logic [ADDR_W-1:0] out_b_q, out_b_d;

    logic [1:0] wr_req, wr_gnt;
    logic       any_wr, starved, rd_grant, wr_grant;

    // Requests are masked during reset so nothing is granted or advanced.
    assign wr_req = {wr1_valid, wr0_valid} & {2{reset}};
    assign any_wr = |wr_req;

    rr_arbiter2 u_rr_arbiter2 (
        .clock   (clock),
        .reset   (reset),
        .req     (wr_req),
        .advance (wr_grant),
        .gnt     (wr_gnt)
    );

    always_comb begin
        starved  = (starve_q == SW'(STARVE_MAX));
        rd_grant = reset && rd_valid && (!any_wr || starved);
        wr_grant = any_wr && !rd_grant;

        wr0_ready = wr_grant && wr_gnt[0];
        wr1_ready = wr_grant && wr_gnt[1];
        rd_ready  = rd_grant;

        rf_enable = wr_grant;
        rf_in_c   = wr_gnt[1] ? wr1_addr : wr0_addr;
        rf_e      = wr_gnt[1] ? wr1_data : wr0_data;

        // Read addresses are held so the register file keeps presenting them.
        rf_out_a = rd_grant ? rd_addr_a : out_a_q;
        rf_out_b = rd_grant ? rd_addr_b : out_b_q;

        rd_resp_valid = reset && (state_q == StRead);
        rd_data_a     = rf_a;
        rd_data_b     = rf_b;
    end

    always_comb begin
        state_d  = StIdle;
        starve_d = starve_q;
        out_a_d  = rf_out_a;
        out_b_d  = rf_out_b;

        if (wr_grant) begin
            state_d = StWrite;
        end else if (rd_grant) begin
            state_d = StRead;
        end

        if (!rd_valid || rd_grant) begin
            starve_d = '0;
        end else if (wr_grant && !starved) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= StIdle;
            starve_q <= '0;
            out_a_q  <= '0;
            out_b_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            out_a_q  <= out_a_d;
            out_b_q  <= out_b_d;
        end
    end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Scoreboard bench: a rule-level model predicts grants and read data; a separate
// monitor pops expected operand pairs whenever the DUT presents a response.
module tb_regfile_port_arbiter;

    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int SMAX = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          wr0_valid, wr0_ready, wr1_valid, wr1_ready, rd_valid, rd_ready;
    logic [AW-1:0] wr0_addr, wr1_addr, rd_addr_a, rd_addr_b;
    logic [DW-1:0] wr0_data, wr1_data;
    logic          rd_resp_valid, rf_enable;
    logic [DW-1:0] rd_data_a, rd_data_b, rf_e, rf_a, rf_b;
    logic [AW-1:0] rf_in_c, rf_out_a, rf_out_b;

    regfile_port_arbiter #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .STARVE_MAX (SMAX)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .wr0_valid     (wr0_valid),
        .wr0_ready     (wr0_ready),
        .wr0_addr      (wr0_addr),
        .wr0_data      (wr0_data),
        .wr1_valid     (wr1_valid),
        .wr1_ready     (wr1_ready),
        .wr1_addr      (wr1_addr),
        .wr1_data      (wr1_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_addr_a     (rd_addr_a),
        .rd_addr_b     (rd_addr_b),
        .rd_resp_valid (rd_resp_valid),
        .rd_data_a     (rd_data_a),
        .rd_data_b     (rd_data_b),
        .rf_enable     (rf_enable),
        .rf_in_c       (rf_in_c),
        .rf_e          (rf_e),
        .rf_out_a      (rf_out_a),
        .rf_out_b      (rf_out_b),
        .rf_a          (rf_a),
        .rf_b          (rf_b)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int            due;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } exp_t;
    exp_t sb[$];

    logic [DW-1:0] mem    [16];
    logic [DW-1:0] shadow [16];
    int            m_rr, m_starve;
    logic [AW-1:0] m_last_a, m_last_b;

    logic          acc0, acc1, accr;
    int            resp_cnt = 0;
    logic [DW-1:0] last_resp_a, last_resp_b;

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 5) return 32'hA5;
        if (i == 7) return 32'hB7;
        return 32'h1000 + i;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Register file with synchronous read: data appears the cycle after the address.
    always @(posedge clock) begin
        if (rf_enable === 1'b1) mem[rf_in_c] <= rf_e;
        rf_a <= mem[rf_out_a];
        rf_b <= mem[rf_out_b];
    end

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        acc0 <= wr0_valid && wr0_ready;
        acc1 <= wr1_valid && wr1_ready;
        accr <= rd_valid && rd_ready;
    end

    // Reference model: decides each cycle's grant from the arbitration rules.
    always @(negedge clock) begin : predictor
        logic any_w, rd_g;
        int   w;
        exp_t e;
        if (reset !== 1'b1) begin
            check("rst_wr0_ready", wr0_ready, 0);
            check("rst_wr1_ready", wr1_ready, 0);
            check("rst_rd_ready", rd_ready, 0);
            check("rst_rf_enable", rf_enable, 0);
            m_rr     = 0;
            m_starve = 0;
            m_last_a = '0;
            m_last_b = '0;
        end else begin
            any_w = wr0_valid || wr1_valid;
            rd_g  = rd_valid && (!any_w || m_starve == SMAX);
            w     = -1;
            if (any_w && !rd_g) begin
                if (wr0_valid && wr1_valid) w = m_rr;
                else if (wr0_valid)         w = 0;
                else                        w = 1;
            end
            check("wr0_ready", wr0_ready, (w == 0));
            check("wr1_ready", wr1_ready, (w == 1));
            check("rd_ready", rd_ready, rd_g);
            check("rf_enable", rf_enable, (w >= 0));
            if (w == 0) begin
                check("rf_in_c", rf_in_c, wr0_addr);
                check("rf_e", rf_e, wr0_data);
            end else if (w == 1) begin
                check("rf_in_c", rf_in_c, wr1_addr);
                check("rf_e", rf_e, wr1_data);
            end
            check("rf_out_a", rf_out_a, rd_g ? rd_addr_a : m_last_a);
            check("rf_out_b", rf_out_b, rd_g ? rd_addr_b : m_last_b);

            if (w == 0) shadow[wr0_addr] = wr0_data;
            if (w == 1) shadow[wr1_addr] = wr1_data;
            if (w >= 0) m_rr = 1 - w;
            if (!rd_valid || rd_g)              m_starve = 0;
            else if (w >= 0 && m_starve < SMAX) m_starve++;
            if (rd_g) begin
                e.due = cyc + 1;
                e.a   = shadow[rd_addr_a];
                e.b   = shadow[rd_addr_b];
                sb.push_back(e);
                m_last_a = rd_addr_a;
                m_last_b = rd_addr_b;
            end
        end
    end

    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset !== 1'b1) begin
            check("rst_resp_valid", rd_resp_valid, 0);
            sb.delete();
        end else begin
            if (sb.size() > 0 && sb[0].due < cyc) begin
                check("resp_missing", 0, 1);
                void'(sb.pop_front());
            end
            if (rd_resp_valid === 1'b1) begin
                if (sb.size() == 0 || sb[0].due != cyc) begin
                    check("resp_unexpected", rd_resp_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("rd_data_a", rd_data_a, e.a);
                    check("rd_data_b", rd_data_b, e.b);
                    last_resp_a = rd_data_a;
                    last_resp_b = rd_data_b;
                    resp_cnt++;
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clock);
        #1;
        if (acc0) wr0_valid = 1'b0;
        if (acc1) wr1_valid = 1'b0;
        if (accr) rd_valid = 1'b0;
    endtask

    task automatic raise(input int p0, input int p1, input int pr);
        if (!wr0_valid && $urandom_range(0, 99) < p0) begin
            wr0_valid = 1'b1;
            wr0_addr  = AW'($urandom_range(0, 15));
            wr0_data  = $urandom;
        end
        if (!wr1_valid && $urandom_range(0, 99) < p1) begin
            wr1_valid = 1'b1;
            wr1_addr  = AW'($urandom_range(0, 15));
            wr1_data  = $urandom;
        end
        if (!rd_valid && $urandom_range(0, 99) < pr) begin
            rd_valid  = 1'b1;
            rd_addr_a = AW'($urandom_range(0, 15));
            rd_addr_b = AW'($urandom_range(0, 15));
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((wr0_valid || wr1_valid || rd_valid) && n < budget) begin
            cycle();
            n++;
        end
        check({name, "_idle_timeout"}, (wr0_valid || wr1_valid || rd_valid), 0);
    endtask

    task automatic wait_resp(input string name, input int budget);
        int c0 = resp_cnt;
        int n  = 0;
        while (resp_cnt == c0 && n < budget) begin
            cycle();
            n++;
        end
        check({name, "_resp_timeout"}, (resp_cnt != c0), 1);
    endtask

    initial begin : stimulus
        logic [8:0] pat;
        int         c0;
        reset     = 1'b0;
        wr0_valid = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_valid = 1'b0; wr1_addr = '0; wr1_data = '0;
        rd_valid  = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
        for (int i = 0; i < 16; i++) begin
            mem[i]    = init_val(i);
            shadow[i] = init_val(i);
        end

        // Concurrent writers to r3, held from reset; wr0 must go first.
        wr0_valid = 1'b1; wr0_addr = 4'd3; wr0_data = 32'h11;
        wr1_valid = 1'b1; wr1_addr = 4'd3; wr1_data = 32'h22;
        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        check("concurrent_first", {acc0, acc1}, 2'b10);
        cycle();
        check("concurrent_second", {acc0, acc1}, 2'b01);
        rd_valid = 1'b1; rd_addr_a = 4'd3; rd_addr_b = 4'd3;
        wait_resp("concurrent_read", 10);
        check("concurrent_last_wins", last_resp_a, 32'h22);

        // Lone read latency and data.
        rd_valid = 1'b1; rd_addr_a = 4'd5; rd_addr_b = 4'd7;
        cycle();
        check("lone_read_ready", accr, 1);
        wait_resp("lone_read", 10);
        check("lone_read_a", last_resp_a, 32'hA5);
        check("lone_read_b", last_resp_b, 32'hB7);

        // Starvation: all three requesters continuously valid.
        raise(100, 100, 100);
        for (int i = 0; i < 9; i++) begin
            cycle();
            pat[i] = accr;
            raise(100, 100, 100);
        end
        check("starve_pattern", pat, 9'b100_100_100);
        wait_idle("starve", 20);
        cycle();

        // Read-after-write: write r2 then read it in the following cycle.
        wr0_valid = 1'b1; wr0_addr = 4'd2; wr0_data = 32'hDEAD;
        rd_valid  = 1'b1; rd_addr_a = 4'd2; rd_addr_b = 4'd2;
        wait_resp("raw", 10);
        check("raw_data", last_resp_a, 32'hDEAD);
        wait_idle("raw", 10);

        // Reset in the cycle after a read grant; wr0 again first afterwards.
        rd_valid = 1'b1; rd_addr_a = 4'd1; rd_addr_b = 4'd4;
        cycle();
        check("prereset_read_ready", accr, 1);
        reset = 1'b0;
        wr0_valid = 1'b1; wr0_addr = 4'd9; wr0_data = 32'h900D;
        wr1_valid = 1'b1; wr1_addr = 4'd9; wr1_data = 32'hBAD0;
        c0 = resp_cnt;
        repeat (2) cycle();
        check("reset_no_resp", resp_cnt, c0);
        reset = 1'b1;
        cycle();
        check("post_reset_wr0_first", {acc0, acc1}, 2'b10);
        wait_idle("post_reset", 10);

        // Idle window: model checks rf_enable low and held read addresses.
        repeat (10) cycle();

        // Randomized traffic at varying load.
        for (int k = 0; k < 3000; k++) begin
            case ((k / 500) % 3)
                0:       raise(20, 20, 20);
                1:       raise(50, 40, 60);
                default: raise(90, 90, 90);
            endcase
            cycle();
        end
        wait_idle("random", 50);
        repeat (3) cycle();
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
